// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard scan-code receiver: key code
// width, prefix byte values, receiver FSM states and the frame parity check.
package kbd_pkg;

  localparam int KEYCODE_WIDTH = 9;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on both lines, a glitch
// filter on the clock line and a one-cycle strobe on each accepted falling
// clock edge. The filtered level starts at 1 (bus idle) after reset.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_clk_meta;
  logic          r_clk_sync;
  logic          r_dat_meta;
  logic          r_dat_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Bring both asynchronous lines into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else if (r_clk_sync == r_level) begin
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_clk_sync;
      r_cnt   <= '0;
      r_fall  <= ~r_clk_sync;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_fall <= 1'b0;
    end
  end

  assign o_data = r_dat_sync;
  assign o_fall = r_fall;

endmodule

// File: rtl/kbd_scancode_rx.sv
// PS/2 keyboard scan-code receiver. Deframes 11-bit PS/2 frames, folds the
// E0 (extended) and F0 (break) prefixes into the following byte and emits
// make/brake strobes with a registered key code, or frame_err on a rejected
// or timed-out frame.
// Optional build macro KBD_RX_TYPEMATIC_FILTER_EN: suppress make strobes for
// typematic repeats of the key currently held down.
module kbd_scancode_rx #(
  parameter int KEYCODE_WIDTH  = kbd_pkg::KEYCODE_WIDTH,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [KEYCODE_WIDTH-1:0] keyCode,
  output logic                     make,
  output logic                     brake,
  output logic                     frame_err
);

  import kbd_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                     w_fall;
  logic                     w_data;
  rx_state_t                r_state;
  rx_state_t                w_state_nxt;
  logic [2:0]               r_bitcnt;
  logic [7:0]               r_shift;
  logic                     r_par;
  logic                     r_ext;
  logic                     r_brk;
  logic [TW-1:0]            r_tocnt;
  logic [KEYCODE_WIDTH-1:0] r_key;
  logic                     r_make;
  logic                     r_brake;
  logic                     r_ferr;

  logic                     w_timeout;
  logic                     w_frame_done;
  logic                     w_frame_ok;
  logic [KEYCODE_WIDTH-1:0] w_code;
  logic                     w_make;
  logic                     w_brake;
  logic                     w_ferr;
  logic                     w_set_ext;
  logic                     w_set_brk;
  logic                     w_clr_flags;
  logic                     w_held_hit;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_data    (w_data),
    .o_fall    (w_fall)
  );

  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tocnt == TO_LAST);
  assign w_code    = KEYCODE_WIDTH'({r_ext, r_shift});

`ifdef KBD_RX_TYPEMATIC_FILTER_EN
  logic [KEYCODE_WIDTH-1:0] r_held;
  logic                     r_held_vld;

  assign w_held_hit = r_held_vld && (r_held == w_code);

  // Track the key currently held so its auto-repeat makes can be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held     <= '0;
      r_held_vld <= 1'b0;
    end else if (w_brake && w_held_hit) begin
      r_held_vld <= 1'b0;
    end else if (w_make) begin
      r_held     <= w_code;
      r_held_vld <= 1'b1;
    end
  end
`else
  assign w_held_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: advance one step per filtered falling edge, bail on timeout.
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    w_state_nxt = w_data ? IDLE : DATA;
        DATA:    w_state_nxt = (r_bitcnt == 3'd7) ? PARITY : DATA;
        PARITY:  w_state_nxt = STOP;
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM outputs: classify the completed byte and decide strobes and flag updates.
  always_comb begin
    w_frame_done = (r_state == STOP) && w_fall;
    w_frame_ok   = w_frame_done && w_data && odd_parity_ok(r_shift, r_par);
    w_make       = 1'b0;
    w_brake      = 1'b0;
    w_ferr       = 1'b0;
    w_set_ext    = 1'b0;
    w_set_brk    = 1'b0;
    w_clr_flags  = 1'b0;
    if (w_timeout) begin
      w_ferr      = 1'b1;
      w_clr_flags = 1'b1;
    end else if (w_frame_done && !w_frame_ok) begin
      w_ferr      = 1'b1;
      w_clr_flags = 1'b1;
    end else if (w_frame_ok) begin
      if (r_shift == PREFIX_EXT) begin
        w_set_ext = 1'b1;
      end else if (r_shift == PREFIX_BRK) begin
        w_set_brk = 1'b1;
      end else begin
        w_clr_flags = 1'b1;
        w_brake     = r_brk;
        w_make      = !r_brk && !w_held_hit;
      end
    end else begin
      w_ferr = 1'b0;
    end
  end

  // Frame datapath: bit counter, shift register, parity bit, prefix flags, timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_tocnt  <= '0;
    end else begin
      if ((r_state == IDLE) || w_fall || w_timeout) begin
        r_tocnt <= '0;
      end else begin
        r_tocnt <= r_tocnt + TW'(1);
      end
      if (w_fall) begin
        case (r_state)
          IDLE: r_bitcnt <= 3'd0;
          DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          PARITY:  r_par <= w_data;
          default: r_par <= r_par;
        endcase
      end
      if (w_clr_flags) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else begin
        if (w_set_ext) r_ext <= 1'b1;
        if (w_set_brk) r_brk <= 1'b1;
      end
    end
  end

  // Registered outputs: key code loads only together with a make/brake strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= '0;
      r_make  <= 1'b0;
      r_brake <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_make  <= w_make;
      r_brake <= w_brake;
      r_ferr  <= w_ferr;
      if (w_make || w_brake) begin
        r_key <= w_code;
      end
    end
  end

  assign keyCode   = r_key;
  assign make      = r_make;
  assign brake     = r_brake;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_kbd_scancode_rx.sv
// Self-checking bench for kbd_scancode_rx: a byte-level model predicts the
// queue of strobes from the scan-code rules; every clock cycle the outputs
// are compared against it, plus literal expectations per directed test.
module tb_kbd_scancode_rx;

  localparam int TO = 400;
  localparam int H  = 40;
  localparam int GAP = 60;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] keyCode;
  logic       make;
  logic       brake;
  logic       frame_err;

  typedef struct packed {
    logic [2:0] strobes;
    logic [8:0] code;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;
  int         cnt_mk;
  int         cnt_br;
  int         cnt_fe;
  logic [8:0] m_key;
  logic       m_ext;
  logic       m_brk;
  logic [8:0] m_held;
  logic       m_held_vld;

  kbd_scancode_rx #(
    .KEYCODE_WIDTH (9),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keyCode  (keyCode),
    .make     (make),
    .brake    (brake),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, then compare the outputs with the model.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (make)      cnt_mk++;
    if (brake)     cnt_br++;
    if (frame_err) cnt_fe++;
    if (reset) begin
      chk("reset_outputs", {20'd0, keyCode, frame_err, brake, make}, 32'd0);
    end else if (make || brake || frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, frame_err, brake, make}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {29'd0, frame_err, brake, make}, {29'd0, e.strobes});
        if (e.strobes != 3'b100) m_key = e.code;
        chk("strobe_key", {23'd0, keyCode}, {23'd0, m_key});
      end
    end else begin
      chk("key_hold", {23'd0, keyCode}, {23'd0, m_key});
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [8:0] code);
    exp_t e;
    e.strobes = s;
    e.code    = code;
    exp_q.push_back(e);
  endtask

  // Scan-code rules applied to one received byte.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [8:0] code;
    if (!ok) begin
      push_exp(3'b100, 9'd0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      code = {m_ext, b};
      if (m_brk) begin
        push_exp(3'b010, code);
        if (m_held_vld && m_held == code) m_held_vld = 1'b0;
      end else begin
`ifdef KBD_RX_TYPEMATIC_FILTER_EN
        if (!(m_held_vld && m_held == code)) begin
          m_held     = code;
          m_held_vld = 1'b1;
          push_exp(3'b001, code);
        end
`else
        push_exp(3'b001, code);
`endif
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cycles(H / 2);
      ps2_clk = 1'b0;
      cycles(H);
      ps2_clk = 1'b1;
      cycles(H / 2);
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit flip);
    model_byte(b, !flip);
    send_bits(frame_of(b, flip), 11);
    cycles(GAP);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    m_key = 9'd0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_held_vld = 1'b0;
    exp_q.delete();
    cycles(n);
    reset = 1'b0;
  endtask

  initial begin
    int b_mk;
    int b_br;
    int b_fe;
    n_cmp = 0; n_bad = 0;
    cnt_mk = 0; cnt_br = 0; cnt_fe = 0;
    m_held = 9'd0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    do_reset(5);
    cycles(20);
    chk("reset_key", {23'd0, keyCode}, 32'd0);

    // Single make
    b_mk = cnt_mk; b_br = cnt_br;
    send_byte(8'h75, 1'b0);
    chk("t1_key", {23'd0, keyCode}, 32'h075);
    chk("t1_makes", cnt_mk - b_mk, 32'd1);
    chk("t1_brakes", cnt_br - b_br, 32'd0);

    // Break sequence
    b_mk = cnt_mk; b_br = cnt_br;
    send_byte(8'hF0, 1'b0);
    chk("t2_f0_silent", (cnt_mk - b_mk) + (cnt_br - b_br), 32'd0);
    send_byte(8'h75, 1'b0);
    chk("t2_key", {23'd0, keyCode}, 32'h075);
    chk("t2_brakes", cnt_br - b_br, 32'd1);

    // Extended make then extended break
    b_mk = cnt_mk; b_br = cnt_br;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    chk("t3_make_key", {23'd0, keyCode}, 32'h16B);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    chk("t3_brk_key", {23'd0, keyCode}, 32'h16B);
    chk("t3_counts", {cnt_mk - b_mk, cnt_br - b_br}, {32'd1, 32'd1});

    // Parity error then good frame
    b_mk = cnt_mk; b_fe = cnt_fe;
    send_byte(8'h74, 1'b1);
    chk("t4_ferr", cnt_fe - b_fe, 32'd1);
    chk("t4_nomake", cnt_mk - b_mk, 32'd0);
    send_byte(8'h74, 1'b0);
    chk("t4_key", {23'd0, keyCode}, 32'h074);

    // Timeout after four data bits
    b_fe = cnt_fe;
    push_exp(3'b100, 9'd0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_bits(frame_of(8'h6B, 1'b0), 5);
    cycles(TO + 60);
    chk("t5_timeout_ferr", cnt_fe - b_fe, 32'd1);
    chk("t5_queue", exp_q.size(), 32'd0);

    // Single-cycle glitches with data low must not start a frame
    ps2_data = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      cyc();
      ps2_clk = 1'b1;
      cycles(20);
    end
    ps2_data = 1'b1;
    cycles(20);
    b_mk = cnt_mk;
    send_byte(8'h6B, 1'b0);
    chk("t6_key", {23'd0, keyCode}, 32'h06B);
    chk("t6_make", cnt_mk - b_mk, 32'd1);

    // Typematic repeats
    b_mk = cnt_mk;
    for (int r = 0; r < 3; r++) send_byte(8'h75, 1'b0);
`ifdef KBD_RX_TYPEMATIC_FILTER_EN
    chk("t7_repeat_makes", cnt_mk - b_mk, 32'd1);
`else
    chk("t7_repeat_makes", cnt_mk - b_mk, 32'd3);
`endif

    // Reset in the middle of a frame
    b_mk = cnt_mk; b_br = cnt_br; b_fe = cnt_fe;
    send_bits(frame_of(8'h1C, 1'b0), 4);
    do_reset(4);
    cycles(TO + 60);
    chk("t8_no_strobe", (cnt_mk - b_mk) + (cnt_br - b_br) + (cnt_fe - b_fe), 32'd0);
    chk("t8_key_zero", {23'd0, keyCode}, 32'd0);
    send_byte(8'h75, 1'b0);
    chk("t8_after_key", {23'd0, keyCode}, 32'h075);
    chk("t8_after_make", cnt_mk - b_mk, 32'd1);

    chk("final_queue", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
